// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage with IF/ID register, one-entry skid buffer for decode
// stalls, and branch redirect that drains any request already issued to memory.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        ack_v;
  logic        occupied_stall;
  logic [31:0] tgt_al;
  logic [31:0] pc_inc;

  // An ack only counts against a request we actually issued.
  assign ack_v          = imem_ack & req_q;
  assign occupied_stall = stall & if_valid_q;
  assign tgt_al         = {branch_target[31:2], 2'b00};
  assign pc_inc         = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (branch_taken)                state_d = (req_q && !ack_v) ? DRAIN : FETCH;
        else if (ack_v && occupied_stall) state_d = HOLD;
      end
      DRAIN:   if (ack_v) state_d = FETCH;
      HOLD:    if (branch_taken || !stall) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    req_d         = (state_d != HOLD);
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    if_valid_d    = 1'b0;
    if_instr_d    = '0;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    skid_vld_d    = skid_vld_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    if (branch_taken) begin
      skid_vld_d = 1'b0;
      // While draining, the old address must stay on the bus; park the target.
      if (state_d == DRAIN) tgt_d = tgt_al;
      else                  pc_d  = tgt_al;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack_v) begin
            pc_d = pc_inc;
            if (occupied_stall) begin
              if_valid_d   = if_valid_q;
              if_instr_d   = if_instr_q;
              skid_vld_d   = 1'b1;
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_q;
            end else begin
              if_valid_d    = 1'b1;
              if_instr_d    = imem_rdata;
              if_pc_d       = pc_q;
              if_pc_plus4_d = pc_inc;
            end
          end else if (occupied_stall) begin
            if_valid_d = if_valid_q;
            if_instr_d = if_instr_q;
          end
        end
        DRAIN: if (ack_v) pc_d = tgt_q;
        HOLD: begin
          if (stall) begin
            if_valid_d = if_valid_q;
            if_instr_d = if_instr_q;
          end else begin
            if_valid_d    = skid_vld_q;
            if_instr_d    = skid_vld_q ? skid_instr_q : 32'h0;
            if_pc_d       = skid_pc_q;
            if_pc_plus4_d = skid_pc_q + 32'd4;
            skid_vld_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q         <= 1'b0;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      skid_vld_q    <= 1'b0;
    end else begin
      req_q         <= req_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      skid_vld_q    <= skid_vld_d;
    end
  end

  // Target and skid payload are qualified by state/skid_vld, so they need no reset.
  always_ff @(posedge clk) begin
    tgt_q        <= tgt_d;
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign opcode      = if_instr_q[31:26];
  assign funct       = if_instr_q[5:0];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage and IF/ID pipeline register for the MIPS datapath. It keeps the PC and fetches from instruction memory over a variable-latency req/ack handshake. It presents the fetched word, plus its `opcode`/`funct` fields, to the control unit and decode. It also handles decode stalls, using a one-entry skid buffer, and branch redirects from EX.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset (word aligned)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `imem_req`  out  1  fetch request; held high until acked
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1
- `imem_ack`  in  1  request complete; `imem_rdata` valid this cycle; only meaningful while `imem_req`=1
- `imem_rdata`  in  32  instruction word
- `stall`  in  1  decode/hazard hold; IF/ID must not change
- `branch_taken`  in  1  redirect from EX; flushes IF/ID
- `branch_target`  in  32  redirect address; bits [1:0] ignored (treated as 00)
- `if_valid`  out  1  IF/ID holds a real instruction
- `if_instr`  out  32  IF/ID instruction; 32'h0 (NOP) whenever `if_valid`=0
- `if_pc`  out  32  address of `if_instr`
- `if_pc_plus4`  out  32  `if_pc`+4, mod 2^32
- `opcode`  out  6  `if_instr[31:26]`, combinational
- `funct`  out  6  `if_instr[5:0]`, combinational

## Operation
- **State machine:** FETCH, DRAIN, HOLD. It enters FETCH on reset.
- **FETCH**
  - `imem_req`=1, `imem_addr`=pc.
  - On ack with no stall and no branch: IF/ID loads {rdata, pc, pc+4}, `if_valid`=1, pc<=pc+4.
  - On ack while stall=1 and `if_valid`=1: data goes into the skid buffer {instr, pc}, pc<=pc+4, next state HOLD.
- **HOLD**
  - `imem_req`=0; IF/ID and the skid buffer are frozen.
  - When stall=0: skid moves into IF/ID, the skid is emptied, next state FETCH.
- **DRAIN**
  - Entered when `branch_taken`=1 while a request is outstanding and unacked that cycle.
  - `imem_req` stays high with the old address, because a request is never withdrawn.
  - The ack's data is discarded, then the state returns to FETCH with pc=target.
- **No stall, no ack, no branch:** IF/ID loads a bubble (`if_valid`=0, `if_instr`=0).
- **stall=1 with `if_valid`=0:** an empty register accepts new data. The stall only blocks occupied IF/ID.
- **Branch priority:** branch > stall > normal. When `branch_taken`=1:
  - `if_valid`<=0, `if_instr`<=0, skid cleared.
  - pc<={target[31:2],2'b00}.
  - An ack in the same cycle is discarded, and the next state is FETCH.
  - With an unacked request outstanding, the next state is DRAIN.
  - A second branch during DRAIN replaces the target.
- **Arithmetic:** all PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- **Reset values:** `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_plus4`=0, `opcode`=0, `funct`=0, skid empty.
- **Mid-operation reset:** resets are asynchronous. An outstanding request is abandoned; the memory side is reset by the same `rst_n`.
- **First request:** `imem_req` rises on the first rising edge after `rst_n` deasserts. Addr=`RESET_PC`.
- **Fetch latency:** ack in cycle N puts IF/ID valid in N+1.
  - Single-cycle memory (ack every cycle) sustains 1 instruction/cycle.
  - The next request is issued in cycle N+1 with pc+4.
- **Redirect:** `branch_taken` in cycle N flushes IF/ID at N+1.
  - Target request at N+1, or one cycle after the drain ack.
  - With 1-cycle memory, the target instruction is valid at N+2.
- **Stall release:** skid data appears in IF/ID one cycle after stall falls; the request resumes the same cycle.
- **Outputs:** all registered except `opcode`/`funct`.

## Test plan
- **Reset and sequential fetch:** RESET_PC=32'h100, ack every cycle, rdata=8C820004,00000020,… -> `if_pc` 100,104,108 on consecutive cycles; `opcode`=6'h23 for the first word; `if_pc_plus4`=104.
- **Slow memory:** ack 3 cycles after req -> `imem_addr` stable for 3 cycles; one `if_valid` pulse per ack; bubbles (`if_instr`=0) in between.
- **Stall with skid:** stall=1 for 4 cycles while IF/ID holds pc 104 and an ack for 108 arrives -> IF/ID stays 104; `imem_req`=0 in HOLD; 108 appears the cycle after stall drops; no instruction lost or duplicated.
- **Branch during outstanding request:** request for 0x20 unacked, `branch_taken`=1, target=0x403 -> flush next cycle; the 0x20 data is discarded on its ack; next `imem_addr`=0x400; `if_pc` 0x400 follows.
- **Branch with simultaneous stall and ack:** branch, stall, and ack in the same cycle -> ack data dropped; IF/ID invalid; skid empty; fetch at target.
- **Wrap and async reset:** pc 32'hFFFF_FFFC -> next addr 0. `rst_n` dropped mid-request -> all outputs at reset values immediately, without waiting for a clock edge.
